alu_issue_ctrl: RTL and testbench

Initiator side of the ALU operand/opcode interface. Accepts instruction words (opcode, rd, rs1, rs2) over a valid/ready handshake and reads operands from an internal register file. It drives the combinational ALU's opcode and operand ports, captures the ALU result and writes it back. It guarantees the ALU only ever sees legal opcodes (000-101); illegal instructions are trapped here.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_regfile.sv | 50 +++++
 rtl/alu_issue_ctrl.sv | 152 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Opcode encoding, legality check and instruction format shared by
//          the ALU and its issue controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int REG_N_DEF  = 8;
    localparam int ADDR_W_DEF = $clog2(REG_N_DEF);

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_NOT = 3'b101
    } alu_op_e;

    typedef struct packed {
        logic [2:0]            opcode;
        logic [ADDR_W_DEF-1:0] rd;
        logic [ADDR_W_DEF-1:0] rs1;
        logic [ADDR_W_DEF-1:0] rs2;
    } instr_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op <= 3'b101);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_regfile.sv
// ============================================================================
// Module : alu_regfile
// Brief  : REG_N x DATA_W register file, two async read ports, write-back and
//          preload write ports; write-back wins on an address collision.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_regfile
    import alu_pkg::*;
#(
    parameter int  DATA_W = DATA_W_DEF,
    parameter int  REG_N  = REG_N_DEF,
    localparam int ADDR_W = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              pl_en,
    input  logic [ADDR_W-1:0] pl_addr,
    input  logic [DATA_W-1:0] pl_data
);

    logic [DATA_W-1:0] mem_q [REG_N];

    always_ff @(posedge clk) begin
        for (int i = 0; i < REG_N; i++) begin
            if (!rst_n) begin
                mem_q[i] <= '0;
            end else if (wb_en && (wb_addr == ADDR_W'(i))) begin
                mem_q[i] <= wb_data;
            end else if (pl_en && (pl_addr == ADDR_W'(i))) begin
                mem_q[i] <= pl_data;
            end
        end
    end

    // Reads return pre-write contents, so a same-cycle preload is not bypassed.
    assign rd_data_a = mem_q[rd_addr_a];
    assign rd_data_b = mem_q[rd_addr_b];

endmodule

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// ============================================================================
// Module : alu_issue_ctrl
// Brief  : Accepts instructions, reads operands, drives the combinational ALU
//          for one cycle and writes the result back; traps illegal opcodes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int  DATA_W = DATA_W_DEF,
    parameter int  REG_N  = REG_N_DEF,
    localparam int ADDR_W = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_opcode,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [2:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_inputA,
    output logic [DATA_W-1:0] alu_inputB,
    input  logic [DATA_W-1:0] alu_result,
    output logic              done,
    output logic [ADDR_W-1:0] done_rd,
    output logic [DATA_W-1:0] done_data,
    output logic              illegal_op,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              illegal_q, illegal_d;

    logic [DATA_W-1:0] rf_rd_a;
    logic [DATA_W-1:0] rf_rd_b;
    logic              wb_en;

    alu_regfile #(
        .DATA_W (DATA_W),
        .REG_N  (REG_N)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (in_rs1),
        .rd_data_a (rf_rd_a),
        .rd_addr_b (in_rs2),
        .rd_data_b (rf_rd_b),
        .wb_en     (wb_en),
        .wb_addr   (rd_q),
        .wb_data   (res_q),
        .pl_en     (wr_en),
        .pl_addr   (wr_addr),
        .pl_data   (wr_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            rd_q      <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            res_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            res_q     <= res_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rd_d       = rd_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        res_d      = res_q;
        illegal_d  = illegal_q;
        in_ready   = 1'b0;
        alu_opcode = ALU_ADD;
        alu_inputA = '0;
        alu_inputB = '0;
        done       = 1'b0;
        done_rd    = '0;
        done_data  = '0;
        wb_en      = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Illegal opcodes are trapped here and never reach the ALU.
                    if (is_legal_op(in_opcode)) begin
                        op_d    = in_opcode;
                        rd_d    = in_rd;
                        opa_d   = rf_rd_a;
                        opb_d   = rf_rd_b;
                        state_d = S_EXEC;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                alu_opcode = op_q;
                alu_inputA = opa_q;
                alu_inputB = opb_q;
                res_d      = alu_result;
                state_d    = S_WB;
            end
            S_WB: begin
                wb_en     = 1'b1;
                done      = 1'b1;
                done_rd   = rd_q;
                done_data = res_q;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign illegal_op = illegal_q;
    assign busy       = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// ============================================================================
// Module : tb_alu_issue_ctrl
// Brief  : Self-checking bench for alu_issue_ctrl with a behavioural ALU and
//          an array-based register-file reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_issue_ctrl;

    localparam int DATA_W = 16;
    localparam int REG_N  = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_opcode;
    logic [ADDR_W-1:0] in_rd, in_rs1, in_rs2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [2:0]        alu_opcode;
    logic [DATA_W-1:0] alu_inputA, alu_inputB, alu_result;
    logic              done;
    logic [ADDR_W-1:0] done_rd;
    logic [DATA_W-1:0] done_data;
    logic              illegal_op;
    logic              busy;

    int                n_tests = 0;
    int                n_fail  = 0;
    logic [DATA_W-1:0] rf_m [REG_N];
    logic              illegal_m;
    logic [DATA_W-1:0] last_res;

    always #5 clk = ~clk;

    alu_issue_ctrl #(
        .DATA_W (DATA_W),
        .REG_N  (REG_N)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .alu_opcode (alu_opcode),
        .alu_inputA (alu_inputA),
        .alu_inputB (alu_inputB),
        .alu_result (alu_result),
        .done       (done),
        .done_rd    (done_rd),
        .done_data  (done_data),
        .illegal_op (illegal_op),
        .busy       (busy)
    );

    // Combinational ALU the controller talks to.
    always_comb begin
        alu_result = 16'hDEAD;
        case (alu_opcode)
            3'd0: alu_result = alu_inputA + alu_inputB;
            3'd1: alu_result = alu_inputA - alu_inputB;
            3'd2: alu_result = alu_inputA & alu_inputB;
            3'd3: alu_result = alu_inputA | alu_inputB;
            3'd4: alu_result = alu_inputA ^ alu_inputB;
            3'd5: alu_result = ~alu_inputA;
            default: alu_result = 16'hDEAD;
        endcase
    end

    function automatic logic [DATA_W-1:0] spec_result(input logic [2:0] op,
                                                      input logic [DATA_W-1:0] a,
                                                      input logic [DATA_W-1:0] b);
        int ia, ib;
        ia = int'(a);
        ib = int'(b);
        case (op)
            3'd0:    return 16'((ia + ib) % 65536);
            3'd1:    return 16'((ia - ib + 65536) % 65536);
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return 16'(65535 - ia);
            default: return 16'h0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        rf_m[a] = d;
    endtask

    // Issue one instruction from IDLE; optional preloads in the accept cycle
    // and in the write-back cycle.
    task automatic issue(input logic [2:0] op, input logic [ADDR_W-1:0] rd,
                         input logic [ADDR_W-1:0] rs1, input logic [ADDR_W-1:0] rs2,
                         input logic acc_pl, input logic [ADDR_W-1:0] acc_addr,
                         input logic [DATA_W-1:0] acc_data,
                         input logic wb_pl, input logic [ADDR_W-1:0] wb_addr,
                         input logic [DATA_W-1:0] wb_data);
        logic [DATA_W-1:0] a, b, r;
        check("ready_idle", in_ready, 1);
        in_valid  = 1'b1;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        wr_en     = acc_pl;
        wr_addr   = acc_addr;
        wr_data   = acc_data;
        a = rf_m[rs1];
        b = rf_m[rs2];
        tick();
        in_valid = 1'b0;
        wr_en    = 1'b0;
        if (acc_pl) rf_m[acc_addr] = acc_data;
        if (op > 3'd5) begin
            illegal_m = 1'b1;
            check("illegal_flag", illegal_op, illegal_m);
            check("illegal_busy", busy, 0);
            check("illegal_ready", in_ready, 1);
            check("illegal_alu_op", alu_opcode, 0);
            check("illegal_done", done, 0);
            return;
        end
        r = spec_result(op, a, b);
        check("exec_busy", busy, 1);
        check("exec_ready", in_ready, 0);
        check("exec_done", done, 0);
        check("exec_alu_op", alu_opcode, op);
        check("exec_A", alu_inputA, a);
        check("exec_B", alu_inputB, b);
        tick();
        check("wb_done", done, 1);
        check("wb_rd", done_rd, rd);
        check("wb_data", done_data, r);
        check("wb_ready", in_ready, 0);
        check("wb_alu_op", alu_opcode, 0);
        check("wb_A", alu_inputA, 0);
        last_res = done_data;
        wr_en   = wb_pl;
        wr_addr = wb_addr;
        wr_data = wb_data;
        tick();
        wr_en = 1'b0;
        if (wb_pl && (wb_addr != rd)) rf_m[wb_addr] = wb_data;
        rf_m[rd] = r;
        check("post_done", done, 0);
        check("post_busy", busy, 0);
        check("illegal_sticky", illegal_op, illegal_m);
    endtask

    task automatic issue_plain(input logic [2:0] op, input logic [ADDR_W-1:0] rd,
                               input logic [ADDR_W-1:0] rs1, input logic [ADDR_W-1:0] rs2);
        issue(op, rd, rs1, rs2, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_rd = '0; in_rs1 = '0;
        in_rs2 = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; last_res = '0;
        illegal_m = 1'b0;
        for (int i = 0; i < REG_N; i++) rf_m[i] = '0;
        tick(); tick(); tick();
        rst_n = 1'b1;
        tick();
        check("rst_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_done_rd", done_rd, 0);
        check("rst_done_data", done_data, 0);
        check("rst_illegal", illegal_op, 0);
        check("rst_alu_op", alu_opcode, 0);
        check("rst_A", alu_inputA, 0);
        check("rst_B", alu_inputB, 0);

        // ADD
        preload(3'd1, 16'h0005);
        preload(3'd2, 16'h0003);
        issue_plain(3'd0, 3'd3, 3'd1, 3'd2);
        check("add_const", last_res, 16'h0008);
        issue_plain(3'd3, 3'd0, 3'd3, 3'd3);
        check("rf3_readback", last_res, 16'h0008);

        // SUB wrap, then NOT
        preload(3'd1, 16'h0000);
        preload(3'd2, 16'h0001);
        issue_plain(3'd1, 3'd4, 3'd1, 3'd2);
        check("sub_wrap", last_res, 16'hFFFF);
        issue_plain(3'd5, 3'd5, 3'd4, 3'd0);
        check("not_const", last_res, 16'h0000);

        // Illegal, then legal AND with sticky flag
        issue_plain(3'd7, 3'd6, 3'd1, 3'd2);
        check("illegal_after", illegal_op, 1);
        preload(3'd1, 16'hF0F0);
        preload(3'd2, 16'h0FF0);
        issue_plain(3'd2, 3'd7, 3'd1, 3'd2);
        check("and_const", last_res, 16'h00F0);
        check("illegal_kept", illegal_op, 1);

        // Back-to-back with in_valid held high
        preload(3'd1, 16'h0010);
        preload(3'd2, 16'h0020);
        in_valid = 1'b1; in_opcode = 3'd0; in_rd = 3'd3; in_rs1 = 3'd1; in_rs2 = 3'd2;
        tick();
        in_opcode = 3'd1; in_rd = 3'd4; in_rs1 = 3'd3; in_rs2 = 3'd1;
        check("b2b_ready_exec", in_ready, 0);
        check("b2b_busy_exec", busy, 1);
        tick();
        check("b2b_ready_wb", in_ready, 0);
        check("b2b_done1", done, 1);
        check("b2b_data1", done_data, 16'h0030);
        tick();
        check("b2b_ready_idle", in_ready, 1);
        check("b2b_nodone", done, 0);
        tick();
        in_valid = 1'b0;
        check("b2b_exec2_op", alu_opcode, 1);
        check("b2b_exec2_A", alu_inputA, 16'h0030);
        check("b2b_exec2_B", alu_inputB, 16'h0010);
        tick();
        check("b2b_done2", done, 1);
        check("b2b_rd2", done_rd, 4);
        check("b2b_data2", done_data, 16'h0020);
        tick();
        rf_m[3] = 16'h0030;
        rf_m[4] = 16'h0020;

        // Preload colliding with write-back, preload elsewhere, accept-cycle preload
        preload(3'd1, 16'h1200);
        preload(3'd2, 16'h0034);
        issue(3'd4, 3'd6, 3'd1, 3'd2, 1'b0, '0, '0, 1'b1, 3'd6, 16'hAAAA);
        issue(3'd4, 3'd6, 3'd1, 3'd2, 1'b0, '0, '0, 1'b1, 3'd7, 16'h5555);
        issue_plain(3'd3, 3'd0, 3'd6, 3'd7);
        check("collide_or", last_res, 16'h5775);
        issue(3'd3, 3'd0, 3'd6, 3'd6, 1'b1, 3'd6, 16'hFFFF, 1'b0, '0, '0);
        check("no_bypass", last_res, 16'h1234);

        // Randomised traffic against the model
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) < 3) begin
                preload(3'($urandom_range(0, 7)), 16'($urandom));
            end else begin
                issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 16'($urandom),
                      ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 16'($urandom));
            end
        end

        // Reset during EXEC abandons the instruction and clears the file
        preload(3'd1, 16'h0101);
        in_valid = 1'b1; in_opcode = 3'd0; in_rd = 3'd2; in_rs1 = 3'd1; in_rs2 = 3'd1;
        tick();
        in_valid = 1'b0;
        check("rst_mid_exec_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_mid_done", done, 0);
        tick();
        check("rst_mid_done2", done, 0);
        check("rst_mid_ready", in_ready, 1);
        check("rst_mid_illegal", illegal_op, 0);
        illegal_m = 1'b0;
        for (int i = 0; i < REG_N; i++) rf_m[i] = '0;
        for (int i = 0; i < REG_N; i++) begin
            issue_plain(3'd3, 3'(i), 3'(i), 3'(i));
            check("rst_rf_zero", last_res, 16'h0000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
